// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: widths, FSM state
// encoding and the latched command record.
package alu_ctrl_pkg;

  localparam int DW   = 8;               // datapath width, matches the ALU
  localparam int NREG = 4;               // register-file depth
  localparam int AW   = $clog2(NREG);    // register address width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Command fields that must survive from accept to the EXEC edge.
  typedef struct packed {
    logic [3:0]    s;     // ALU function select
    logic          m;     // 0 arithmetic, 1 logic
    logic          cn;    // explicit carry-in
    logic          usec;  // take carry-in from the stored carry flag
    logic [AW-1:0] rd;    // writeback destination
    logic          wb;    // write result back to rd
  } cmd_t;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// NREG x DW register file: two asynchronous read ports and one write path
// that merges the EXEC writeback with the external load port.
module alu_regfile
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic [AW-1:0] i_ra_addr,
  output logic [DW-1:0] o_ra_data,
  input  logic [AW-1:0] i_rb_addr,
  output logic [DW-1:0] o_rb_data
);

  logic [DW-1:0] r_mem [NREG];

  // Per-entry write: writeback beats a load aimed at the same entry,
  // while a load to a different entry still lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the file is small and must read as zero after reset, so it is
      // built from flops with a reset rather than an unreset RAM macro.
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values;
        // blocking here would create order-dependent simulation behaviour.
        if (i_wb_en && (i_wb_addr == AW'(i)))
          r_mem[i] <= i_wb_data;
        else if (i_ld_en && (i_ld_addr == AW'(i)))
          r_mem[i] <= i_ld_data;
      end
    end
  end

  // Asynchronous reads return pre-edge contents, so an operand fetched on
  // the same edge as a load sees the old value.
  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer around an external combinational ALU: accepts a command,
// fetches operands, drives the ALU for one cycle, captures result and
// flags, optionally writes back, and holds the result until consumed.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  // command port
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_s,
  input  logic          cmd_m,
  input  logic          cmd_cn,
  input  logic          cmd_usec,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic          cmd_imm_en,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_wb,
  // external register-file load
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  // ALU drive and return
  output logic [3:0]    alu_s,
  output logic          alu_m,
  output logic          alu_cn,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_f,
  input  logic          alu_co,
  input  logic          alu_fz,
  // result port
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          c_flag,
  output logic          z_flag
);

  state_t        r_state;
  state_t        w_next_state;
  cmd_t          r_cmd;
  cmd_t          w_cmd_in;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_res;
  logic          r_c;
  logic          r_z;
  logic          w_accept;
  logic          w_exec;
  logic [DW-1:0] w_ra_data;
  logic [DW-1:0] w_rb_data;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_cmd_in = '{s: cmd_s, m: cmd_m, cn: cmd_cn, usec: cmd_usec,
                      rd: cmd_rd, wb: cmd_wb};

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wb_en   (w_exec && r_cmd.wb),
    .i_wb_addr (r_cmd.rd),
    .i_wb_data (alu_f),
    .i_ld_en   (ld_en),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data),
    .i_ra_addr (cmd_ra),
    .o_ra_data (w_ra_data),
    .i_rb_addr (cmd_rb),
    .o_rb_data (w_rb_data)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: IDLE -> EXEC on accept, one EXEC cycle, DONE until consumed.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)               w_next_state = ST_EXEC;
      ST_EXEC:                             w_next_state = ST_DONE;
      ST_DONE: if (res_valid && res_ready) w_next_state = ST_IDLE;
      default:                             w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs and the EXEC strobe.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    w_exec    = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EXEC: w_exec    = 1'b1;
      ST_DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Command/operand latch at accept; result and flag capture at the EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd <= w_cmd_in;
        r_a   <= w_ra_data;
        r_b   <= cmd_imm_en ? cmd_imm : w_rb_data;
      end
      if (w_exec) begin
        r_res <= alu_f;
        r_c   <= alu_co;
        r_z   <= ~alu_fz;   // ALU reports 0 on A == B
      end
    end
  end

  // ALU inputs follow the latched command; they only matter during EXEC.
  assign alu_s  = r_cmd.s;
  assign alu_m  = r_cmd.m;
  assign alu_cn = r_cmd.usec ? r_c : r_cmd.cn;
  assign alu_a  = r_a;
  assign alu_b  = r_b;

  assign res_data = r_res;
  assign c_flag   = r_c;
  assign z_flag   = r_z;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a small behavioural ALU in the loop.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_s;
  logic       cmd_m, cmd_cn, cmd_usec;
  logic [1:0] cmd_ra, cmd_rb, cmd_rd;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic       cmd_wb;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [3:0] alu_s;
  logic       alu_m, alu_cn;
  logic [7:0] alu_a, alu_b, alu_f;
  logic       alu_co, alu_fz;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       c_flag, z_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cn(cmd_cn), .cmd_usec(cmd_usec),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_co(alu_co), .alu_fz(alu_fz),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .c_flag(c_flag), .z_flag(z_flag)
  );

  // Behavioural ALU subset: add (1001/M=0), A plus Cn (other M=0),
  // XOR (0110), AND (1011), OR (1110), NOT A (other M=1).
  always_comb begin
    {alu_co, alu_f} = 9'd0;
    if (!alu_m) begin
      if (alu_s == 4'b1001)
        {alu_co, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cn};
      else
        {alu_co, alu_f} = {1'b0, alu_a} + {8'd0, alu_cn};
    end else begin
      case (alu_s)
        4'b0110: alu_f = alu_a ^ alu_b;
        4'b1011: alu_f = alu_a & alu_b;
        4'b1110: alu_f = alu_a | alu_b;
        default: alu_f = ~alu_a;
      endcase
    end
    alu_fz = (alu_a != alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Offer a command while IDLE; returns #1 after the accept edge.
  task automatic send_cmd(input logic [3:0] s, input logic m, input logic cn,
                          input logic usec, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic imm_en,
                          input logic [7:0] imm, input logic wb);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_s = s; cmd_m = m; cmd_cn = cn; cmd_usec = usec;
    cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_wb = wb;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_ready_exec", cmd_ready, 0);
    check("res_valid_exec", res_valid, 0);
  endtask

  // Bounded wait for res_valid; expects exactly one edge after accept.
  task automatic wait_res(input int already);
    int n = already;
    while (!res_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 1);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_after_release", res_valid, 0);
    check("cmd_ready_after_release", cmd_ready, 1);
  endtask

  task automatic run(input logic [3:0] s, input logic m, input logic cn,
                     input logic usec, input logic [1:0] ra, input logic [1:0] rb,
                     input logic [1:0] rd, input logic imm_en,
                     input logic [7:0] imm, input logic wb);
    send_cmd(s, m, cn, usec, ra, rb, rd, imm_en, imm, wb);
    wait_res(0);
  endtask

  // Reads a register as A XOR 0x00 with no writeback.
  task automatic read_reg(input logic [1:0] addr, output logic [7:0] val);
    run(4'b0110, 1'b1, 1'b0, 1'b0, addr, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0);
    val = res_data;
    release_res();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_s = '0; cmd_m = 1'b0; cmd_cn = 1'b0; cmd_usec = 1'b0;
    cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_imm_en = 1'b0; cmd_imm = '0; cmd_wb = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_c_flag", c_flag, 0);
    check("rst_z_flag", z_flag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_s", alu_s, 0);
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), v);
      check("rf_reset_zero", v, 0);
    end

    // Lone loads never touch the flags (last read left c=0, z=1)
    load(2'd0, 8'h80);
    load(2'd1, 8'h80);
    load(2'd2, 8'h33);
    check("ld_keeps_c", c_flag, 0);
    check("ld_keeps_z", z_flag, 1);

    // 0x80 + 0x80 -> 0x00, carry, equal operands; writeback to r2
    run(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1);
    check("add80_res", res_data, 8'h00);
    check("add80_c", c_flag, 1);
    check("add80_z", z_flag, 1);
    release_res();
    read_reg(2'd2, v);
    check("add80_wb_r2", v, 8'h00);

    // Chained carry: 0xFF + 0x01 sets c, then r3 + imm 0 + c = 0x01
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    run(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 1'b0);
    check("addff_res", res_data, 8'h00);
    check("addff_c", c_flag, 1);
    check("addff_z", z_flag, 0);
    release_res();
    run(4'b1001, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0);
    check("chain_res", res_data, 8'h01);
    check("chain_c", c_flag, 0);
    check("chain_z", z_flag, 1);
    release_res();

    // Logic XOR 0x5A ^ 0x0F = 0x55, no writeback to r3
    load(2'd1, 8'h5A);
    run(4'b0110, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd3, 1'b1, 8'h0F, 1'b0);
    check("xor_res", res_data, 8'h55);
    check("xor_z", z_flag, 0);
    check("xor_c", c_flag, 0);
    release_res();
    read_reg(2'd3, v);
    check("xor_nowb_r3", v, 8'h00);

    // Backpressure: 0xFF + 0x02 -> 0x01, c=1, held for 5 cycles
    run(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h02, 1'b0);
    cmd_s = 4'b0110; cmd_m = 1'b1; cmd_ra = 2'd1; cmd_imm_en = 1'b1;
    cmd_imm = 8'hAA; cmd_wb = 1'b1; cmd_rd = 2'd3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_res_data", res_data, 8'h01);
      check("bp_c", c_flag, 1);
      check("bp_z", z_flag, 0);
    end
    cmd_valid = 1'b0;
    release_res();
    check("bp_hold_after", res_data, 8'h01);
    read_reg(2'd3, v);
    check("bp_rejected_no_wb", v, 8'h00);

    // res_ready held high through EXEC: no early completion, 3-cycle command
    res_ready = 1'b1;
    run(4'b1001, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0);
    check("rdyhi_res", res_data, 8'h5C);
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("rdyhi_idle_valid", res_valid, 0);
    check("rdyhi_idle_ready", cmd_ready, 1);

    // Load coinciding with accept: operand sees the old r1 (0x5A)
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h11;
    send_cmd(4'b0110, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0);
    ld_en = 1'b0;
    wait_res(0);
    check("ld_accept_old", res_data, 8'h5A);
    release_res();
    read_reg(2'd1, v);
    check("ld_accept_new", v, 8'h11);

    // Writeback and load to r2 on the same edge: writeback (0x0F) wins
    send_cmd(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 8'h10, 1'b1);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
    @(posedge clk); #1;
    ld_en = 1'b0;
    wait_res(1);
    check("wbld_res", res_data, 8'h0F);
    check("wbld_c", c_flag, 1);
    release_res();
    read_reg(2'd2, v);
    check("wbld_r2", v, 8'h0F);

    // Reset during EXEC aborts the command
    send_cmd(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 8'h01, 1'b1);
    check("pre_rst_alu_a", alu_a, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_c", c_flag, 0);
    check("mid_rst_z", z_flag, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_s", alu_s, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_res_valid", res_valid, 0);
    read_reg(2'd3, v);
    check("post_rst_r3", v, 8'h00);
    read_reg(2'd0, v);
    check("post_rst_r0", v, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
